// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_access_ctrl_if : CPU, bridge and data-memory signal bundle               |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface dm_access_ctrl_if #(
    parameter int AW = 12
);
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_size;
    logic          cpu_unsigned;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic          cpu_done;
    logic [31:0]   cpu_rdata;
    logic          cpu_adel;
    logic          cpu_ades;

    logic          br_req;
    logic          br_we;
    logic [31:0]   br_addr;
    logic [31:0]   br_wdata;
    logic          br_done;
    logic [31:0]   br_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Controller side: serves requesters, drives the memory port.
    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_done, cpu_rdata, cpu_adel, cpu_ades,
        input  br_req, br_we, br_addr, br_wdata,
        output br_done, br_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory side.
    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_done, cpu_rdata, cpu_adel, cpu_ades,
        output br_req, br_we, br_addr, br_wdata,
        input  br_done, br_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_access_ctrl : data-memory sequencer/arbiter with load extension and     |
// |                  read-modify-write sub-word stores. Revision 1.0            |
// +----------------------------------------------------------------------------+
module dm_access_ctrl #(
    parameter int AW         = 12,
    parameter int STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             reset,
    dm_access_ctrl_if.slave  bus
);
    localparam int c_CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_LIM);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;     // 1 = bridge
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [AW+1:0]      r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic [c_CNT_W-1:0] r_starve;

    logic               w_acc_cpu;
    logic               w_acc_br;
    logic               w_cpu_win;
    logic               w_cpu_mis;
    logic [7:0]         w_lb;
    logic [15:0]        w_lh;
    logic [31:0]        w_ext;
    logic [31:0]        w_merge;

    logic               w_cpu_done;
    logic               w_br_done;
    logic               w_mem_en;
    logic               w_mem_we;
    logic               w_unused;

    assign w_unused  = ^{bus.cpu_addr[31:AW+2], bus.br_addr[31:AW+2]};
    assign w_cpu_win = bus.cpu_req & ~(bus.br_req & (r_starve == c_STARVE_MAX));
    assign w_cpu_mis = ((bus.cpu_size == 2'b01) & bus.cpu_addr[0]) |
                       (bus.cpu_size[1] & (bus.cpu_addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_acc_cpu  = 1'b0;
        w_acc_br   = 1'b0;
        w_cpu_done = 1'b0;
        w_br_done  = 1'b0;
        w_mem_en   = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cpu_win) begin
                    w_acc_cpu = 1'b1;
                    if (w_cpu_mis)
                        w_next = S_ERR;
                    else if (bus.cpu_we && bus.cpu_size[1])
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end else if (bus.br_req) begin
                    w_acc_br = 1'b1;
                    w_next   = bus.br_we ? S_WR : S_RD;
                end
            end
            S_RD: begin
                w_mem_en = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: w_next = r_we ? S_WR : S_DONE;
            S_WR: begin
                w_mem_en = 1'b1;
                w_mem_we = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                w_cpu_done = ~r_owner;
                w_br_done  = r_owner;
                w_next     = S_IDLE;
            end
            S_ERR: begin
                w_cpu_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane insertion for sub-word stores.
    always_comb begin
        w_lb    = 8'h00;
        w_lh    = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_ext   = bus.mem_rdata;
        w_merge = bus.mem_rdata;
        case (r_addr[1:0])
            2'd0:    w_lb = bus.mem_rdata[7:0];
            2'd1:    w_lb = bus.mem_rdata[15:8];
            2'd2:    w_lb = bus.mem_rdata[23:16];
            default: w_lb = bus.mem_rdata[31:24];
        endcase
        case (r_size)
            2'b00: begin
                w_ext = {{24{w_lb[7] & ~r_uns}}, w_lb};
                w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            end
            2'b01: begin
                w_ext = {{16{w_lh[15] & ~r_uns}}, w_lh};
                w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_ext   = bus.mem_rdata;
                w_merge = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_starve <= '0;
        end else begin
            if (w_acc_cpu) begin
                r_owner <= 1'b0;
                r_we    <= bus.cpu_we;
                r_size  <= bus.cpu_size;
                r_uns   <= bus.cpu_unsigned;
                r_addr  <= bus.cpu_addr[AW+1:0];
                r_wdata <= bus.cpu_wdata;
                r_rdata <= 32'h0;
                if (bus.br_req && (r_starve != c_STARVE_MAX))
                    r_starve <= r_starve + 1'b1;
            end else if (w_acc_br) begin
                r_owner  <= 1'b1;
                r_we     <= bus.br_we;
                r_size   <= 2'b10;
                r_uns    <= 1'b0;
                r_addr   <= bus.br_addr[AW+1:0];
                r_wdata  <= bus.br_wdata;
                r_rdata  <= 32'h0;
                r_starve <= '0;
            end
            if (r_state == S_WAIT) begin
                if (r_we)
                    r_wdata <= w_merge;
                else
                    r_rdata <= w_ext;
            end
        end
    end

    assign bus.cpu_done  = w_cpu_done;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_done;
    assign bus.cpu_rdata = (w_cpu_done && r_state == S_DONE) ? r_rdata : 32'h0;
    assign bus.cpu_adel  = (r_state == S_ERR) & ~r_we;
    assign bus.cpu_ades  = (r_state == S_ERR) & r_we;
    assign bus.br_done   = w_br_done;
    assign bus.br_rdata  = w_br_done ? r_rdata : 32'h0;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_en ? r_addr[AW+1:2] : '0;
    assign bus.mem_wdata = w_mem_we ? r_wdata : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dm_access_ctrl : randomized and directed bench against a word-array     |
// |                     reference model. Revision 1.0                           |
// +----------------------------------------------------------------------------+
module tb_dm_access_ctrl;
    localparam int AW  = 12;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dm_access_ctrl_if #(.AW(AW)) bus ();

    dm_access_ctrl #(.AW(AW), .STARVE_LIM(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port memory seen by the controller.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference view of memory contents, indexed by word.
    logic [31:0] ref_mem [0:(1<<AW)-1];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (int'(a[1:0]) * 8)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'b01) begin
            v = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] m;
        int          sh;
        if (sz[1]) return d;
        m  = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
        sh = (sz == 2'b00) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
        return (w & ~(m << sh)) | ((d & m) << sh);
    endfunction

    task automatic cpu_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output int nmem,
                          output logic adel, output logic ades, output logic bad);
        @(negedge clk);
        bus.cpu_req      = 1'b1;
        bus.cpu_we       = we;
        bus.cpu_size     = sz;
        bus.cpu_unsigned = uns;
        bus.cpu_addr     = addr;
        bus.cpu_wdata    = wd;
        lat = 0; nmem = 0; bad = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_en) begin
                nmem++;
                if (bus.mem_addr !== addr[AW+1:2]) bad = 1'b1;
            end
            if (bus.br_done !== 1'b0) bad = 1'b1;
            if (bus.cpu_stall !== !bus.cpu_done) bad = 1'b1;
        end while (!bus.cpu_done && lat < 20);
        rd   = bus.cpu_rdata;
        adel = bus.cpu_adel;
        ades = bus.cpu_ades;
        @(negedge clk);
        bus.cpu_req = 1'b0;
    endtask

    // Runs one CPU access and checks it against the reference model.
    task automatic cpu_check(input string tag, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] rd);
        int          lat, nmem, e_lat, e_nmem;
        logic        adel, ades, bad, mis;
        logic [31:0] e_rd;
        int          idx;
        idx    = int'(addr[AW+1:2]);
        mis    = ((sz == 2'b01) && addr[0]) || (sz[1] && addr[1:0] != 2'b00);
        e_lat  = mis ? 1 : (!we ? 3 : (sz[1] ? 2 : 4));
        e_nmem = mis ? 0 : ((we && !sz[1]) ? 2 : 1);
        e_rd   = (mis || we) ? 32'h0 : ref_load(ref_mem[idx], addr, sz, uns);
        cpu_op(we, sz, uns, addr, wd, rd, lat, nmem, adel, ades, bad);
        chk({tag, "_lat"},  lat,  e_lat);
        chk({tag, "_nmem"}, nmem, e_nmem);
        chk({tag, "_adel"}, {31'b0, adel}, {31'b0, mis & !we});
        chk({tag, "_ades"}, {31'b0, ades}, {31'b0, mis & we});
        chk({tag, "_bus"},  {31'b0, bad},  32'h0);
        if (!we) chk({tag, "_rdata"}, rd, e_rd);
        if (we && !mis) ref_mem[idx] = ref_store(ref_mem[idx], addr, sz, wd);
    endtask

    task automatic br_check(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
        int lat;
        int idx;
        idx = int'(addr[AW+1:2]);
        @(negedge clk);
        bus.br_req   = 1'b1;
        bus.br_we    = we;
        bus.br_addr  = addr;
        bus.br_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.br_done && lat < 20);
        chk({tag, "_lat"}, lat, we ? 2 : 3);
        if (!we) chk({tag, "_rdata"}, bus.br_rdata, ref_mem[idx]);
        else ref_mem[idx] = wd;
        @(negedge clk);
        bus.br_req = 1'b0;
    endtask

    initial begin : main
        logic [31:0] rd;
        int          cyc, ncpu, nbr, overlap, badrd;
        int          gap [2];
        logic [31:0] brd [2];

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_unsigned = 0;
        bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.br_req = 0; bus.br_we = 0; bus.br_addr = 0; bus.br_wdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {bus.cpu_stall, bus.cpu_done, bus.cpu_adel, bus.cpu_ades, bus.br_done,
             bus.mem_en, bus.mem_we, 26'b0},
            32'h0);
        chk("reset_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("reset_mem_addr",  {20'b0, bus.mem_addr}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        cpu_check("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        cpu_check("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
        chk("lw10_const", rd, 32'hDEADBEEF);

        cpu_check("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h8081F0F1, rd);
        cpu_check("lb23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd);
        chk("lb23_const", rd, 32'hFFFFFF80);
        cpu_check("lbu21", 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd);
        chk("lbu21_const", rd, 32'h000000F0);
        cpu_check("lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd);
        chk("lh22_const", rd, 32'hFFFF8081);
        cpu_check("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd);
        chk("lhu20_const", rd, 32'h0000F0F1);

        cpu_check("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd);
        cpu_check("sb31", 1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AA, rd);
        cpu_check("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, rd);
        cpu_check("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd);
        chk("lw30_const", rd, 32'hBEEFAA44);

        cpu_check("lw05_mis", 1'b0, 2'b10, 1'b0, 32'h05, 32'h0, rd);
        cpu_check("sh07_mis", 1'b1, 2'b01, 1'b0, 32'h07, 32'h1234, rd);

        // Wrap: upper address bits beyond the memory are dropped.
        cpu_check("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h0001_0010, 32'h0, rd);
        chk("lw_wrap_const", rd, 32'hDEADBEEF);

        br_check("br_sw40", 1'b1, 32'h40, 32'hCAFEF00D);
        br_check("br_lw40", 1'b0, 32'h43, 32'h0);

        for (int i = 0; i < 16; i++)
            if (i != 4 && i != 8 && i != 12)
                cpu_check("pre", 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd);
        for (int i = 0; i < 60; i++)
            cpu_check("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom, rd);

        // Starvation: CPU keeps issuing loads while the bridge waits.
        cpu_check("sw50", 1'b1, 2'b10, 1'b0, 32'h50, 32'h01020304, rd);
        br_check("br_sw60", 1'b1, 32'h60, 32'hA5A55A5A);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10;
        bus.cpu_unsigned = 1'b0; bus.cpu_addr = 32'h50;
        bus.br_req = 1'b1; bus.br_we = 1'b0; bus.br_addr = 32'h60;
        cyc = 0; ncpu = 0; nbr = 0; overlap = 0; badrd = 0;
        gap[0] = -1; gap[1] = -1; brd[0] = 32'h0; brd[1] = 32'h0;
        while (nbr < 2 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.cpu_done && bus.br_done) overlap++;
            if (bus.cpu_done) begin
                ncpu++;
                if (bus.cpu_rdata !== ref_mem[20]) badrd++;
            end
            if (bus.br_done) begin
                gap[nbr] = ncpu;
                brd[nbr] = bus.br_rdata;
                ncpu = 0;
                nbr++;
            end
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.br_req  = 1'b0;
        chk("arb_bridge_served", nbr, 2);
        chk("arb_first_gap", gap[0], LIM);
        chk("arb_second_gap", gap[1], LIM);
        chk("arb_br_rdata0", brd[0], ref_mem[24]);
        chk("arb_br_rdata1", brd[1], ref_mem[24]);
        chk("arb_overlap", overlap, 0);
        chk("arb_cpu_rdata", badrd, 0);

        // Reset during the write cycle of a sub-word store.
        cpu_check("sw70", 1'b1, 2'b10, 1'b0, 32'h70, 32'h55667788, rd);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b00;
        bus.cpu_unsigned = 1'b0; bus.cpu_addr = 32'h71; bus.cpu_wdata = 32'hCC;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(bus.mem_en && bus.mem_we) && cyc < 20);
        chk("rst_wr_cycle", cyc, 3);
        #2 reset = 1'b0;
        #1;
        chk("rst_mem_drop", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
        chk("rst_done_low", {31'b0, bus.cpu_done}, 32'h0);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cpu_check("lw70_after_rst", 1'b0, 2'b10, 1'b0, 32'h70, 32'h0, rd);
        chk("lw70_const", rd, 32'h55667788);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Sequencer and arbiter for the single-port, word-wide synchronous data memory. It serves two requesters: the CPU MEM stage (byte/half/word loads and stores) and a low-priority word-only bridge port for debug/DMA. It performs the load extension and the sub-word write merge through a read-modify-write sequence. It also flags misaligned CPU accesses and raises a pipeline stall until each access completes.

Parameters:
AW, 12, data-memory word-address width (2^AW words).
STARVE_LIM, 4, number of consecutive CPU wins over a pending bridge request before the bridge is forced a grant.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request; held stable until cpu_done
cpu_we  input  1  1=store, 0=load
cpu_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
cpu_unsigned  input  1  zero-extend loads (lbu/lhu) when 1
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data; byte/half taken from low bits
cpu_stall  output  1  cpu_req & ~cpu_done (combinational)
cpu_done  output  1  one-cycle completion pulse
cpu_rdata  output  32  extended load data, valid while cpu_done=1
cpu_adel  output  1  misaligned load, pulses with cpu_done
cpu_ades  output  1  misaligned store, pulses with cpu_done
br_req  input  1  bridge request; held until br_done
br_we  input  1  bridge store
br_addr  input  32  byte address; bits[1:0] ignored
br_wdata  input  32  bridge store word
br_done  output  1  one-cycle completion pulse
br_rdata  output  32  load word, valid while br_done=1
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable (whole word)
mem_addr  output  AW  word address = latched addr[AW+1:2]; higher bits truncated (wrap)
mem_wdata  output  32  write word
mem_rdata  input  32  read word, valid the cycle after mem_en & ~mem_we

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. Starvation counter 0. Latched request regs 0. mem_en drops immediately, so an in-flight write is abandoned.
- States: IDLE, RD, WAIT, WR, DONE, ERR. Owner bit (CPU/bridge) latched on accept.
- IDLE arbitration:
  - If cpu_req and not (br_req and starve_cnt==STARVE_LIM), accept CPU.
  - Else if br_req, accept bridge and clear starve_cnt.
  - starve_cnt increments (saturating at STARVE_LIM) on every CPU accept while br_req=1.
  - On accept, latch owner, we, size, unsigned, addr and wdata.
- Alignment check (CPU only, at accept):
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - Misaligned -> ERR. No memory access.
- Routing from IDLE:
  - load or sub-word store -> RD.
  - word store (CPU or bridge) -> WR.
- RD: mem_en=1, mem_we=0 -> WAIT.
- WAIT: sample mem_rdata.
  - Load: compute extended data into the rdata register -> DONE.
    - byte lane = addr[1:0], half lane = addr[1].
    - Sign-extend from the lane MSB unless unsigned.
  - Sub-word store: merge the low byte/half of wdata into the addressed lane, keep the other lanes -> WR.
- WR: mem_en=1, mem_we=1, mem_wdata = merged or full word -> DONE.
- DONE: owner's done pulses one cycle; rdata valid -> IDLE. A new accept is possible the next cycle.
- ERR: cpu_done=1 with cpu_adel (load) or cpu_ades (store) -> IDLE. cpu_rdata=0.
- Latency, with the accept cycle as T (done asserted in the listed cycle):
  - word/sub-word load: T+3.
  - word store: T+2.
  - sub-word store: T+4.
  - misaligned: T+1.
- mem_* are 0 in IDLE, WAIT, DONE and ERR.
- Idle outputs: cpu_rdata/br_rdata are 0 except in DONE. Done pulses never overlap.
- A requester dropping its req mid-operation does not abort the sequence; its done still pulses.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x10, then lw @0x10 -> mem_addr=4, store done at T+2, load done at T+3 with cpu_rdata=0xDEADBEEF.
- Word at 0x20 = 0x8081F0F1:
  - lb @0x23 -> 0xFFFFFF80.
  - lbu @0x21 -> 0x000000F0.
  - lh @0x22 -> 0xFFFF8081.
  - lhu @0x20 -> 0x0000F0F1.
- Word at 0x30 = 0x11223344; sb 0xAA @0x31, then sh 0xBEEF @0x32, then lw @0x30 -> 0xBEEFAA44. Each store done at T+4.
- Misaligned:
  - lw @0x05 -> cpu_adel pulse at T+1, mem_en never asserted.
  - sh @0x07 -> cpu_ades pulse.
- Arbitration: cpu_req held with back-to-back loads while br_req=1 -> the 5th grant goes to the bridge (after 4 CPU wins). br_done returns the word and starve_cnt clears.
- Assert reset during the WR cycle of a sub-word store -> mem_en/mem_we drop the same cycle. State is IDLE. The memory word is unchanged on readback after reset release.
